// File: rtl/red_prec_pipe.sv
// red_prec_pkg: number-format descriptor shared by the precision converters.
//   dconf_t = {dtype, sign, prec (total bits), frac (fraction bits)}.
//   INT is the frac == 0 special case of FXP.
package red_prec_pkg;
  typedef enum logic {FXP = 1'b0, INT = 1'b1} dtype_e;
  typedef enum logic {Disable = 1'b0, Enable = 1'b1} sign_e;
  typedef struct packed {
    dtype_e      dtype;
    sign_e       sign;
    logic [15:0] prec;
    logic [15:0] frac;
  } dconf_t;
endpackage

// red_prec_pipe: streaming precision reducer, I_CONF -> narrower O_CONF.
//   Stage 1 drops fraction bits using RND_MODE; stage 2 saturates to the output range.
//   Latency 2 cycles, 1 sample/cycle; stage k ready = !valid_k || ready_(k+1), data held on stall.
// Ports:
//   clk, reset_            clock, synchronous active-low reset
//   in_valid/in_ready/in_data     upstream handshake, I_CONF sample
//   out_valid/out_ready/out_data  downstream handshake, O_CONF sample
//   out_sat                out_data was clamped (qualified by out_valid)
//   clr                    clears sat_cnt and sat_sticky
//   sat_cnt, sat_sticky    saturated-transfer counter (holds at all-ones) and sticky flag
module red_prec_pipe
  import red_prec_pkg::*;
#(
  parameter dconf_t I_CONF   = '{dtype: FXP, sign: Enable, prec: 16'd16, frac: 16'd4},
  parameter dconf_t O_CONF   = '{dtype: FXP, sign: Enable, prec: 16'd8,  frac: 16'd2},
  parameter int     RND_MODE = 2,
  parameter int     CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [I_CONF.prec-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [O_CONF.prec-1:0]   out_data,
  output logic                     out_sat,
  input  logic                     clr,
  output logic [CNT_W-1:0]         sat_cnt,
  output logic                     sat_sticky
);

  localparam int I_PREC   = int'(I_CONF.prec);
  localparam int I_FRAC   = int'(I_CONF.frac);
  localparam int O_PREC   = int'(O_CONF.prec);
  localparam int O_FRAC   = int'(O_CONF.frac);
  localparam int I_INT    = I_PREC - I_FRAC;
  localparam int O_INT    = O_PREC - O_FRAC;
  localparam bit I_SIGNED = (I_CONF.sign == Enable);
  localparam bit O_SIGNED = (O_CONF.sign == Enable);
  localparam int S        = I_FRAC - O_FRAC;
  // One bit for the rounding carry plus one so unsigned inputs stay positive
  // when handled as signed; both signednesses then share a single datapath.
  localparam int W        = I_PREC + 2;

  if (O_FRAC > I_FRAC || O_INT > I_INT) begin : g_bad_conf
    $error("red_prec_pipe: O_CONF must not have more frac or int bits than I_CONF");
  end

  localparam logic signed [W-1:0] SAT_MAX = O_SIGNED ?
      $signed((W'(1) << (O_PREC - 1)) - W'(1)) : $signed((W'(1) << O_PREC) - W'(1));
  localparam logic signed [W-1:0] SAT_MIN = O_SIGNED ?
      $signed(-(W'(1) << (O_PREC - 1))) : $signed(W'(0));

  // ---------------- stage 1: rounding ----------------
  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;

  always_comb begin
    if (I_SIGNED) ext = W'($signed(in_data));
    else          ext = $signed(W'(in_data));
  end

  if (S == 0) begin : g_no_round
    assign rnd = ext;
  end else begin : g_round
    localparam logic [W-1:0] HALF = W'(1) << (S - 1);
    logic signed [W-1:0] flr;
    logic signed [W-1:0] up;
    logic                tie;

    assign flr = ext >>> S;
    assign up  = (ext + $signed(HALF)) >>> S;
    // Dropped bits exactly 100..0: halfway between flr and flr+1.
    assign tie = (in_data[S-1:0] == HALF[S-1:0]);

    always_comb begin
      if (RND_MODE == 0)      rnd = flr;
      else if (RND_MODE == 1) rnd = up;
      // At a tie pick whichever of flr / flr+1 is even.
      else if (tie)           rnd = flr + $signed({{(W-1){1'b0}}, flr[0]});
      else                    rnd = up;
    end
  end

  logic                v1;
  logic signed [W-1:0] r1;
  logic                rdy1;
  logic                rdy2;

  assign rdy2     = !out_valid || out_ready;
  assign rdy1     = !v1 || rdy2;
  assign in_ready = rdy1;

  // ---------------- stage 2: saturation ----------------
  logic [O_PREC-1:0] sat_d;
  logic              sat_f;

  always_comb begin
    sat_d = r1[O_PREC-1:0];
    sat_f = 1'b0;
    if (r1 > SAT_MAX) begin
      sat_d = SAT_MAX[O_PREC-1:0];
      sat_f = 1'b1;
    end else if (r1 < SAT_MIN) begin
      sat_d = SAT_MIN[O_PREC-1:0];
      sat_f = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      v1        <= 1'b0;
      r1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (rdy1) begin
        v1 <= in_valid;
        if (in_valid) r1 <= rnd;
      end
      if (rdy2) begin
        out_valid <= v1;
        if (v1) begin
          out_data <= sat_d;
          out_sat  <= sat_f;
        end
      end
    end
  end

  // ---------------- saturation statistics ----------------
  logic sat_evt;
  assign sat_evt = out_valid && out_ready && out_sat;

  // clr wins first, then a same-cycle event is counted on top of the cleared value.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      sat_cnt    <= '0;
      sat_sticky <= 1'b0;
    end else if (clr) begin
      sat_cnt    <= sat_evt ? CNT_W'(1) : '0;
      sat_sticky <= sat_evt;
    end else if (sat_evt) begin
      if (!(&sat_cnt)) sat_cnt <= sat_cnt + CNT_W'(1);
      sat_sticky <= 1'b1;
    end
  end

endmodule
